mmmul_engine: RTL and testbench

Parametrised matrix-matrix multiplier computing RESULT = A × B (+ C optionally), signed two's-complement integer arithmetic. Successor to the single-dot-product sequencer. Generalises element width and adds LANES parallel MAC lanes, a start/busy/done handshake, an accumulate-with-C mode and optional saturation. Sits beside the dot-product blocks as the layer compute engine of the ANN datapath.

---
 rtl/mmmul_pkg.sv | 51 +++++
 rtl/mmmul_lane.sv | 55 +++++
 rtl/mmmul_engine.sv | 205 ++++++++++++++++++++
 tb/tb_mmmul_engine.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmmul_pkg.sv
// rtl/mmmul_pkg.sv - shared types and arithmetic helpers for mmmul_engine
//
// Purpose: FSM state type, index/accumulator width helpers and the
// saturate-or-wrap output function used by every MAC lane.
// Ports: none (package).
package mmmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_WRITE,
    ST_DONE
  } state_e;

  // Widest accumulator the output helper handles; covers DATA_W up to 64.
  localparam int MAX_ACC_W = 160;

  // Accumulator width that cannot overflow for a K-term dot product plus C.
  function automatic int acc_width(input int data_w, input int k);
    return 2 * data_w + $clog2(k + 1) + 1;
  endfunction

  // Index width for an array dimension of n entries (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clamp to the signed data_w range when sat_en, else pass through; the
  // caller keeps the low data_w bits, which gives wrap in the unsaturated case.
  function automatic logic signed [MAX_ACC_W-1:0] sat_trunc(
    input logic signed [MAX_ACC_W-1:0] acc,
    input int                          data_w,
    input logic                        sat_en
  );
    logic signed [MAX_ACC_W-1:0] max_v;
    logic signed [MAX_ACC_W-1:0] min_v;
    logic signed [MAX_ACC_W-1:0] res;
    max_v = (MAX_ACC_W'(1) << (data_w - 1)) - MAX_ACC_W'(1);
    min_v = ~max_v;
    res   = acc;
    if (sat_en) begin
      if (acc > max_v) begin
        res = max_v;
      end else if (acc < min_v) begin
        res = min_v;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mmmul_lane.sv
// rtl/mmmul_lane.sv - one signed multiply-accumulate lane
//
// Purpose: accumulator that is loaded with an initial value, accumulates
// a_i*b_i, and presents a saturated or wrapped DATA_W view of its sum.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   load_i        load accumulator with init_i (has priority over mac_i)
//   init_i        signed initial value (C element or 0)
//   mac_i         add a_i*b_i to the accumulator
//   a_i, b_i      signed operands
//   sat_en_i      1: clamp output, 0: wrap output
//   out_o         DATA_W result view of the accumulator
module mmmul_lane
  import mmmul_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 2 * DATA_W + 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     load_i,
  input  logic signed [DATA_W-1:0] init_i,
  input  logic                     mac_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  input  logic                     sat_en_i,
  output logic        [DATA_W-1:0] out_o
);

  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [2*DATA_W-1:0] prod;

  assign prod = (2 * DATA_W)'(a_i) * (2 * DATA_W)'(b_i);

  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = ACC_W'(init_i);
    end else if (mac_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign out_o = DATA_W'(sat_trunc(MAX_ACC_W'(acc_q), DATA_W, sat_en_i));

endmodule

// File: rtl/mmmul_engine.sv
// rtl/mmmul_engine.sv - tiled matrix-matrix multiplier RESULT = A x B (+ C)
//
// Purpose: computes each RESULT row in tiles of LANES columns; every tile
// takes COLS1 accumulate cycles plus one write cycle.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   start_i        request, accepted only while idle
//   acc_en_i       add C to the product (sampled with start)
//   sat_en_i       saturate instead of wrap (sampled with start)
//   mat_a_i        A [ROWS1][COLS1]
//   mat_b_i        B [COLS1][COLS2]
//   mat_c_i        C [ROWS1][COLS2]
//   busy_o         high from accept until the done cycle ends
//   done_o         one-cycle completion pulse
//   result_o       RESULT [ROWS1][COLS2], held until the next run writes it
module mmmul_engine
  import mmmul_pkg::*;
#(
  parameter int ROWS1  = 4,
  parameter int COLS1  = 4,
  parameter int COLS2  = 4,
  parameter int DATA_W = 32,
  parameter int LANES  = 1
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     start_i,
  input  logic                                     acc_en_i,
  input  logic                                     sat_en_i,
  input  logic [ROWS1-1:0][COLS1-1:0][DATA_W-1:0]  mat_a_i,
  input  logic [COLS1-1:0][COLS2-1:0][DATA_W-1:0]  mat_b_i,
  input  logic [ROWS1-1:0][COLS2-1:0][DATA_W-1:0]  mat_c_i,
  output logic                                     busy_o,
  output logic                                     done_o,
  output logic [ROWS1-1:0][COLS2-1:0][DATA_W-1:0]  result_o
);

  localparam int TILES = (COLS2 + LANES - 1) / LANES;
  localparam int ACC_W = acc_width(DATA_W, COLS1);
  localparam int RIW   = idx_width(ROWS1);
  localparam int KIW   = idx_width(COLS1);
  localparam int TIW   = idx_width(TILES);
  localparam int CIW   = idx_width(COLS2);
  localparam int CW    = $clog2(TILES * LANES + 1);

  state_e                                  state_q, state_d;
  logic [RIW-1:0]                          r_q, r_d;
  logic [TIW-1:0]                          t_q, t_d;
  logic [KIW-1:0]                          k_q, k_d;
  logic [ROWS1-1:0][COLS2-1:0][DATA_W-1:0] result_q, result_d;
  logic [ROWS1-1:0][COLS1-1:0][DATA_W-1:0] a_q;
  logic [COLS1-1:0][COLS2-1:0][DATA_W-1:0] b_q;
  logic [ROWS1-1:0][COLS2-1:0][DATA_W-1:0] c_q;
  logic                                    acc_en_q;
  logic                                    sat_en_q;

  logic                                    accept;
  logic                                    load;
  logic                                    mac;
  logic [DATA_W-1:0]                       a_op;
  logic                                    in_range [LANES];
  logic [CIW-1:0]                          col_idx  [LANES];
  logic [DATA_W-1:0]                       lane_out [LANES];

  assign a_op = a_q[r_q][k_q];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [CW-1:0]     col_cur;
    logic [CW-1:0]     col_nxt;
    logic              in_cur;
    logic              in_nxt;
    logic [CIW-1:0]    ci_cur;
    logic [CIW-1:0]    ci_nxt;
    logic [DATA_W-1:0] b_op;
    logic [DATA_W-1:0] init_v;

    assign col_cur = CW'(t_q) * CW'(LANES) + CW'(l);
    assign col_nxt = CW'(t_d) * CW'(LANES) + CW'(l);
    assign in_cur  = col_cur < CW'(COLS2);
    assign in_nxt  = col_nxt < CW'(COLS2);
    assign ci_cur  = in_cur ? CIW'(col_cur) : '0;
    assign ci_nxt  = in_nxt ? CIW'(col_nxt) : '0;
    // Lanes past the last column see a zero operand so their sum stays inert.
    assign b_op    = in_cur ? b_q[k_q][ci_cur] : '0;

    // The initial value is needed on the accept edge, before the operand
    // registers hold C, so in IDLE it comes straight from the inputs.
    always_comb begin
      init_v = '0;
      if (in_nxt) begin
        if (state_q == ST_IDLE) begin
          if (acc_en_i) init_v = mat_c_i[r_d][ci_nxt];
        end else begin
          if (acc_en_q) init_v = c_q[r_d][ci_nxt];
        end
      end
    end

    mmmul_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load_i   (load),
      .init_i   (init_v),
      .mac_i    (mac),
      .a_i      (a_op),
      .b_i      (b_op),
      .sat_en_i (sat_en_q),
      .out_o    (lane_out[l])
    );

    assign in_range[l] = in_cur;
    assign col_idx[l]  = ci_cur;
  end

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    t_d      = t_q;
    k_d      = k_q;
    result_d = result_q;
    accept   = 1'b0;
    load     = 1'b0;
    mac      = 1'b0;
    busy_o   = (state_q != ST_IDLE);
    done_o   = (state_q == ST_DONE);
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          load    = 1'b1;
          r_d     = '0;
          t_d     = '0;
          k_d     = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        mac = 1'b1;
        if (k_q == KIW'(COLS1 - 1)) begin
          state_d = ST_WRITE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_WRITE: begin
        for (int l = 0; l < LANES; l++) begin
          if (in_range[l]) result_d[r_q][col_idx[l]] = lane_out[l];
        end
        if (t_q == TIW'(TILES - 1) && r_q == RIW'(ROWS1 - 1)) begin
          state_d = ST_DONE;
        end else begin
          if (t_q == TIW'(TILES - 1)) begin
            t_d = '0;
            r_d = r_q + 1'b1;
          end else begin
            t_d = t_q + 1'b1;
          end
          k_d     = '0;
          load    = 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      r_q      <= '0;
      t_q      <= '0;
      k_q      <= '0;
      result_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      acc_en_q <= 1'b0;
      sat_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      t_q      <= t_d;
      k_q      <= k_d;
      result_q <= result_d;
      if (accept) begin
        a_q      <= mat_a_i;
        b_q      <= mat_b_i;
        c_q      <= mat_c_i;
        acc_en_q <= acc_en_i;
        sat_en_q <= sat_en_i;
      end
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_mmmul_engine.sv
// tb/tb_mmmul_engine.sv - self-checking bench for mmmul_engine
module tb_mmmul_engine;

  logic       clk;
  logic       rst;
  logic [2:0] start;
  logic       acc_en;
  logic       sat_en;
  logic [2:0] busy;
  logic [2:0] done;

  logic [1:0][1:0][31:0] a32, b32, c32, res0, res1;
  logic [1:0][1:0][7:0]  a8;
  logic [1:0][2:0][7:0]  b8, c8, res2;

  longint ma [0:1][0:1];
  longint mb [0:1][0:2];
  longint mc [0:1][0:2];
  longint ex [0:1][0:2];
  longint prev_last [0:2];

  int total;
  int bad;

  // u0: 32-bit 2x2x2, one lane; u1: same shape, two lanes;
  // u2: 8-bit 2x2x3, two lanes (second tile has an unused lane).
  mmmul_engine #(.ROWS1(2), .COLS1(2), .COLS2(2), .DATA_W(32), .LANES(1)) u0 (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .acc_en_i(acc_en), .sat_en_i(sat_en),
    .mat_a_i(a32), .mat_b_i(b32), .mat_c_i(c32),
    .busy_o(busy[0]), .done_o(done[0]), .result_o(res0));

  mmmul_engine #(.ROWS1(2), .COLS1(2), .COLS2(2), .DATA_W(32), .LANES(2)) u1 (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .acc_en_i(acc_en), .sat_en_i(sat_en),
    .mat_a_i(a32), .mat_b_i(b32), .mat_c_i(c32),
    .busy_o(busy[1]), .done_o(done[1]), .result_o(res1));

  mmmul_engine #(.ROWS1(2), .COLS1(2), .COLS2(3), .DATA_W(8), .LANES(2)) u2 (
    .clk_i(clk), .rst_i(rst), .start_i(start[2]), .acc_en_i(acc_en), .sat_en_i(sat_en),
    .mat_a_i(a8), .mat_b_i(b8), .mat_c_i(c8),
    .busy_o(busy[2]), .done_o(done[2]), .result_o(res2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint get_res(input int w, input int r, input int j);
    case (w)
      0:       return longint'($signed(res0[r][j]));
      1:       return longint'($signed(res1[r][j]));
      default: return longint'($signed(res2[r][j]));
    endcase
  endfunction

  function automatic int cols_of(input int w);
    return (w == 2) ? 3 : 2;
  endfunction

  function automatic longint rnd(input int wd);
    longint v;
    v = longint'($urandom);
    return (v <<< (64 - wd)) >>> (64 - wd);
  endfunction

  // Reference: exact sum of products in 128 bits, then clamp or wrap.
  task automatic model(input int wd, input int n, input bit acc, input bit sat);
    logic signed [127:0] s;
    logic signed [127:0] lim;
    longint v;
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < n; j++) begin
        if (acc) s = 128'(mc[r][j]);
        else     s = 128'sd0;
        for (int k = 0; k < 2; k++) s += 128'(ma[r][k]) * 128'(mb[k][j]);
        lim = 128'sd1 <<< (wd - 1);
        if (sat && s >= lim)       s = lim - 128'sd1;
        else if (sat && s < -lim)  s = -lim;
        v = s[63:0];
        ex[r][j] = (v <<< (64 - wd)) >>> (64 - wd);
      end
    end
  endtask

  task automatic pack();
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 3; j++) begin
        if (j < 2) begin
          a32[r][j] = ma[r][j][31:0];
          a8[r][j]  = ma[r][j][7:0];
          b32[r][j] = mb[r][j][31:0];
          c32[r][j] = mc[r][j][31:0];
        end
        b8[r][j] = mb[r][j][7:0];
        c8[r][j] = mc[r][j][7:0];
      end
    end
  endtask

  task automatic fill_rand(input int wd);
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 3; j++) begin
        if (j < 2) ma[r][j] = rnd(wd);
        mb[r][j] = rnd(wd);
        mc[r][j] = rnd(wd);
      end
    end
  endtask

  task automatic run(input int w, input bit acc, input bit sat, input bit pester);
    int  n;
    int  lat;
    bit  seen;
    bit  busy_drop;
    int  nc;
    nc  = cols_of(w);
    lat = (w == 1) ? 6 : 12;
    model((w == 2) ? 8 : 32, nc, acc, sat);
    pack();
    @(negedge clk);
    acc_en   = acc;
    sat_en   = sat;
    start[w] = 1'b1;
    @(posedge clk);
    #1;
    if (!pester) start[w] = 1'b0;
    chk($sformatf("u%0d_keep_prev", w), get_res(w, 1, nc - 1), prev_last[w]);
    chk($sformatf("u%0d_busy_after_accept", w), 64'(busy[w]), 64'd1);
    seen      = 1'b0;
    busy_drop = 1'b0;
    n         = 1;
    while (n <= 100 && !seen) begin
      if (pester) begin
        a32    = {$urandom, $urandom, $urandom, $urandom};
        a8     = 32'($urandom);
        c32    = {$urandom, $urandom, $urandom, $urandom};
        acc_en = ~acc;
        sat_en = ~sat;
      end
      @(posedge clk);
      #1;
      if (done[w]) seen = 1'b1;
      else begin
        if (!busy[w]) busy_drop = 1'b1;
        n++;
      end
    end
    chk($sformatf("u%0d_latency", w), 64'(n), 64'(lat));
    chk($sformatf("u%0d_busy_held", w), 64'(busy_drop), 64'd0);
    chk($sformatf("u%0d_busy_at_done", w), 64'(busy[w]), 64'd1);
    start[w] = 1'b0;
    acc_en   = 1'b0;
    sat_en   = 1'b0;
    @(posedge clk);
    #1;
    chk($sformatf("u%0d_done_pulse", w), 64'(done[w]), 64'd0);
    chk($sformatf("u%0d_idle_busy", w), 64'(busy[w]), 64'd0);
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < nc; j++) begin
        chk($sformatf("u%0d_res_%0d_%0d", w, r, j), get_res(w, r, j), ex[r][j]);
      end
    end
    prev_last[w] = ex[1][nc - 1];
    @(posedge clk);
    #1;
    chk($sformatf("u%0d_no_second_done", w), 64'(done[w]), 64'd0);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    start  = 3'b000;
    acc_en = 1'b0;
    sat_en = 1'b0;
    a32 = '0; b32 = '0; c32 = '0; a8 = '0; b8 = '0; c8 = '0;
    for (int i = 0; i < 3; i++) prev_last[i] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int w = 0; w < 3; w++) begin
      chk($sformatf("u%0d_reset_busy", w), 64'(busy[w]), 64'd0);
      chk($sformatf("u%0d_reset_done", w), 64'(done[w]), 64'd0);
      for (int r = 0; r < 2; r++)
        for (int j = 0; j < cols_of(w); j++)
          chk($sformatf("u%0d_reset_res", w), get_res(w, r, j), 64'sd0);
    end

    // Directed: [[1,2],[3,4]] x [[5,6],[7,8]] on one and two lanes.
    ma = '{'{1, 2}, '{3, 4}};
    mb = '{'{5, 6, 0}, '{7, 8, 0}};
    mc = '{'{1, 1, 1}, '{1, 1, 1}};
    run(0, 1'b0, 1'b0, 1'b0);
    chk("u0_known_00", get_res(0, 0, 0), 64'sd19);
    chk("u0_known_11", get_res(0, 1, 1), 64'sd50);
    run(1, 1'b0, 1'b0, 1'b0);
    chk("u1_known_01", get_res(1, 0, 1), 64'sd22);
    run(0, 1'b1, 1'b0, 1'b0);
    chk("u0_acc_known_11", get_res(0, 1, 1), 64'sd51);

    // Directed: 2x3 B with an unused lane in the second tile.
    mb = '{'{1, 0, 2}, '{0, 1, 3}};
    run(2, 1'b0, 1'b0, 1'b0);
    chk("u2_known_12", get_res(2, 1, 2), 64'sd18);

    // Saturation and wrap at the 8-bit boundary.
    ma = '{'{100, 100}, '{-100, -100}};
    mb = '{'{1, 1, 1}, '{1, 1, 1}};
    run(2, 1'b0, 1'b1, 1'b0);
    chk("u2_sat_hi", get_res(2, 0, 0), 64'sd127);
    chk("u2_sat_lo", get_res(2, 1, 0), -64'sd128);
    run(2, 1'b0, 1'b0, 1'b0);
    chk("u2_wrap_hi", get_res(2, 0, 0), -64'sd56);
    chk("u2_wrap_lo", get_res(2, 1, 0), 64'sd56);

    // Random operands and modes on every instance.
    for (int it = 0; it < 4; it++) begin
      for (int w = 0; w < 3; w++) begin
        fill_rand((w == 2) ? 8 : 32);
        run(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end
    end

    // start held high with operands churning during the run.
    fill_rand(32);
    run(0, 1'b1, 1'b0, 1'b1);
    fill_rand(8);
    run(2, 1'b1, 1'b1, 1'b1);

    // Reset in the middle of a calculation, then a clean run.
    fill_rand(8);
    pack();
    @(negedge clk);
    start[2] = 1'b1;
    @(posedge clk);
    #1;
    start[2] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("u2_midrst_busy", 64'(busy[2]), 64'd0);
    chk("u2_midrst_done", 64'(done[2]), 64'd0);
    for (int w = 0; w < 3; w++) begin
      for (int r = 0; r < 2; r++)
        for (int j = 0; j < cols_of(w); j++)
          chk($sformatf("u%0d_midrst_res", w), get_res(w, r, j), 64'sd0);
      prev_last[w] = 0;
    end
    run(2, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
